// File: rtl/msk_muxn_skid.sv
// msk_muxn_skid: share-wise N:1 mux for masked channels feeding a registered skid buffer.
// out_data is driven straight from the main register; the skid register absorbs one beat of backpressure.
module msk_muxn_skid #(
    parameter int d     = 2,
    parameter int count = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [N*count*d-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [count*d-1:0]    out_data,
    output logic [SELW-1:0]       out_sel
);
    localparam int W = count * d;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_m_data, r_s_data, w_mux;
    logic [SELW-1:0] r_m_sel, r_s_sel;
    logic            r_in_ready, w_acc, w_con, w_load_m, w_load_s, w_m_from_s;

    // Whole-slice select keeps every share bit in its own lane; out-of-range channels read as zero.
    assign w_mux = (int'(sel) < N) ? in_data[int'(sel)*W +: W] : '0;
    assign w_acc = in_valid & r_in_ready;
    assign w_con = (r_state != EMPTY) & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_m    = 1'b0;
        w_load_s    = 1'b0;
        w_m_from_s  = 1'b0;
        case (r_state)
            EMPTY: begin
                w_state_nxt = w_acc ? ONE : EMPTY;
                w_load_m    = w_acc;
            end
            ONE: begin
                w_state_nxt = (w_acc && !w_con) ? FULL : (!w_acc && w_con) ? EMPTY : ONE;
                w_load_m    = w_acc & w_con;
                w_load_s    = w_acc & ~w_con;
            end
            FULL: begin
                w_state_nxt = w_con ? ONE : FULL;
                w_m_from_s  = w_con;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_m_data   <= '0;
            r_m_sel    <= '0;
            r_s_data   <= '0;
            r_s_sel    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
            if (w_load_m) begin
                r_m_data <= w_mux;
                r_m_sel  <= sel;
            end else if (w_m_from_s) begin
                r_m_data <= r_s_data;
                r_m_sel  <= r_s_sel;
            end
            if (w_load_s) begin
                r_s_data <= w_mux;
                r_s_sel  <= sel;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_m_data;
    assign out_sel   = r_m_sel;
endmodule
